// File: rtl/byte_unstriping.sv
// Two-lane byte unstriper: per-lane FIFOs absorb lane skew, and a two-state
// read FSM rebuilds the original word stream in lane 0 / lane 1 order.

module byte_unstriping_lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: the storage array has no reset; only pointers and count define
    // what is valid, so clearing the data RAM would just cost flops.
    always_ff @(posedge clk_2f) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered storage read combinationally: a word written at edge k is
    // visible here only after k, so there is no fall-through path.
    assign head = mem[rd_ptr];

endmodule

module byte_unstriping #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane_0,
    input  logic             valid_in0,
    input  logic [WIDTH-1:0] lane_1,
    input  logic             valid_in1,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             overflow_err
);

    typedef enum logic {
        EXP_L0 = 1'b0,
        EXP_L1 = 1'b1
    } sel_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    sel_t             sel;
    sel_t             next_sel;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic [AW:0]      count0;
    logic [AW:0]      count1;
    logic             pop0;
    logic             pop1;
    logic             push0;
    logic             push1;
    logic             drop0;
    logic             drop1;
    logic             out_load;
    logic [WIDTH-1:0] out_word;

    // A full lane still accepts a word when its head leaves in the same cycle.
    assign push0 = valid_in0 && ((count0 != FULL_COUNT) || pop0);
    assign push1 = valid_in1 && ((count1 != FULL_COUNT) || pop1);
    assign drop0 = valid_in0 && (count0 == FULL_COUNT) && !pop0;
    assign drop1 = valid_in1 && (count1 == FULL_COUNT) && !pop1;

    byte_unstriping_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo0 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .push    (push0),
        .wr_data (lane_0),
        .pop     (pop0),
        .head    (head0),
        .count   (count0)
    );

    byte_unstriping_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo1 (
        .clk_2f  (clk_2f),
        .reset   (reset),
        .push    (push1),
        .wr_data (lane_1),
        .pop     (pop1),
        .head    (head1),
        .count   (count1)
    );

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            sel <= EXP_L0;
        end else begin
            sel <= next_sel;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        next_sel = sel;
        pop0     = 1'b0;
        pop1     = 1'b0;
        out_load = 1'b0;
        out_word = data_out;
        case (sel)
            EXP_L0: begin
                if (count0 != '0) begin
                    pop0     = 1'b1;
                    out_load = 1'b1;
                    out_word = head0;
                    next_sel = EXP_L1;
                end
            end
            EXP_L1: begin
                if (count1 != '0) begin
                    pop1     = 1'b1;
                    out_load = 1'b1;
                    out_word = head1;
                    next_sel = EXP_L0;
                end
            end
            default: next_sel = EXP_L0;
        endcase
    end

    // data_out holds its last word while the expected lane is empty.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            data_out     <= '0;
            valid_out    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            valid_out <= out_load;
            if (out_load) begin
                data_out <= out_word;
            end
            if (drop0 || drop1) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: expected words are queued in striping
// order as stimulus is written and compared whenever valid_out is seen.

module tb_byte_unstriping;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk_2f = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] lane_0;
    logic             valid_in0;
    logic [WIDTH-1:0] lane_1;
    logic             valid_in1;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             overflow_err;

    logic [WIDTH-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    byte_unstriping #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk_2f       (clk_2f),
        .reset        (reset),
        .lane_0       (lane_0),
        .valid_in0    (valid_in0),
        .lane_1       (lane_1),
        .valid_in1    (valid_in1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .overflow_err (overflow_err)
    );

    always #5 clk_2f = ~clk_2f;

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Scoreboard: every valid_out word must be the oldest outstanding one.
    task automatic sb_check();
        if (valid_out === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) n_pass++;
            else $error("FAIL sb_extra: observed word %h expected no output", data_out);
            if (exp_q.size() > 0) begin
                check("sb_word", data_out, exp_q.pop_front());
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then look at outputs.
    task automatic tick(input logic v0, input logic [WIDTH-1:0] d0,
                        input logic v1, input logic [WIDTH-1:0] d1);
        valid_in0 = v0;
        lane_0    = v0 ? d0 : $urandom;
        valid_in1 = v1;
        lane_1    = v1 ? d1 : $urandom;
        @(posedge clk_2f);
        #1;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        sb_check();
    endtask

    task automatic idle();
        tick(1'b0, '0, 1'b0, '0);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
            idle();
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        // 1: reset held low with random activity on the inputs
        reset     = 1'b0;
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        lane_0    = '0;
        lane_1    = '0;
        for (int i = 0; i < 3; i++) begin
            valid_in0 = 1'($urandom);
            valid_in1 = 1'($urandom);
            lane_0    = $urandom;
            lane_1    = $urandom;
            @(posedge clk_2f);
            #1;
        end
        check("rst_data_out", data_out, '0);
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_overflow", 32'(overflow_err), 0);
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        reset     = 1'b1;

        // 2: basic alternating stream, first word one cycle after its write
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hEEEE_EEEE);
        exp_q.push_back(32'hDDDD_DDDD);
        exp_q.push_back(32'hCCCC_CCCC);
        tick(1'b1, 32'hFFFF_FFFF, 1'b0, '0);
        check("t2_no_fallthrough", 32'(valid_out), 0);
        tick(1'b0, '0, 1'b1, 32'hEEEE_EEEE);
        check("t2_latency1", 32'(valid_out), 1);
        tick(1'b1, 32'hDDDD_DDDD, 1'b0, '0);
        check("t2_valid_w2", 32'(valid_out), 1);
        tick(1'b0, '0, 1'b1, 32'hCCCC_CCCC);
        check("t2_valid_w3", 32'(valid_out), 1);
        idle();
        check("t2_valid_w4", 32'(valid_out), 1);
        drain("t2_drain", 4);

        // 3: lane 1 arrives three cycles ahead of lane 0
        exp_q.push_back(32'h0000_0003);
        exp_q.push_back(32'h0000_0004);
        tick(1'b0, '0, 1'b1, 32'h0000_0004);
        check("t3_wait_a", 32'(valid_out), 0);
        idle();
        check("t3_wait_b", 32'(valid_out), 0);
        idle();
        check("t3_wait_c", 32'(valid_out), 0);
        tick(1'b1, 32'h0000_0003, 1'b0, '0);
        check("t3_wait_d", 32'(valid_out), 0);
        idle();
        check("t3_lane0_first", data_out, 32'h0000_0003);
        drain("t3_drain", 4);

        // 4: one lane-0 word moves sel to lane 1, then five lane-0 words overflow
        exp_q.push_back(32'h1111_1111);
        tick(1'b1, 32'h1111_1111, 1'b0, '0);
        idle();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 32'h4000_0000 + 32'(i), 1'b0, '0);
            check("t4_no_output", 32'(valid_out), 0);
            check("t4_overflow", 32'(overflow_err), (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h5000_0000 + 32'(i));
            exp_q.push_back(32'h4000_0000 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, 32'h5000_0000 + 32'(i));
        end
        drain("t4_drain", 16);
        idle();
        check("t4_dropped_gone", 32'(valid_out), 0);
        idle();
        check("t4_sticky", 32'(overflow_err), 1);

        // 5: reset pulse discards buffered words and returns sel to lane 0
        tick(1'b1, 32'hAAAA_AAAA, 1'b1, 32'h9999_9999);
        reset = 1'b0;
        #1;
        check("t5_rst_data", data_out, '0);
        check("t5_rst_valid", 32'(valid_out), 0);
        check("t5_rst_overflow", 32'(overflow_err), 0);
        @(posedge clk_2f);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_flushed", 32'(valid_out), 0);
        end
        exp_q.push_back(32'h6666_6666);
        exp_q.push_back(32'h7777_7777);
        tick(1'b0, '0, 1'b1, 32'h7777_7777);
        idle();
        check("t5_sel_lane0", 32'(valid_out), 0);
        tick(1'b1, 32'h6666_6666, 1'b0, '0);
        idle();
        check("t5_first_after_rst", data_out, 32'h6666_6666);
        drain("t5_drain", 4);

        // 6: 2*DEPTH+2 alternating words exercise pointer wrap with no gaps
        for (int i = 0; i < 2*DEPTH+2; i++) begin
            exp_q.push_back(32'h6000_0000 + 32'(i));
        end
        for (int i = 0; i < 2*DEPTH+2; i++) begin
            if (i % 2 == 0) begin
                tick(1'b1, 32'h6000_0000 + 32'(i), 1'b0, '0);
            end else begin
                tick(1'b0, '0, 1'b1, 32'h6000_0000 + 32'(i));
            end
            if (i > 0) begin
                check("t6_no_gap", 32'(valid_out), 1);
            end
        end
        idle();
        check("t6_last_valid", 32'(valid_out), 1);
        drain("t6_drain", 4);
        idle();
        check("t6_idle_after", 32'(valid_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
